// File: rtl/coin_pkg.sv
// Shared types and defaults for the coin tally block.
package coin_pkg;

    // Per-beam debounce states; the accepted level is "broken" in the upper two.
    typedef enum logic [1:0] {
        StStableClear  = 2'd0,
        StPendBreak    = 2'd1,
        StStableBroken = 2'd2,
        StPendClear    = 2'd3
    } db_state_e;

    // Coin index constants (bit position in beam_n / coin_mask).
    localparam int unsigned CoinQ    = 0;
    localparam int unsigned CoinD    = 1;
    localparam int unsigned CoinN    = 2;
    localparam int unsigned CoinP    = 3;
    localparam int unsigned NumBeams = 4;

    // Default coin values in cents.
    localparam int unsigned DefValQ = 25;
    localparam int unsigned DefValD = 10;
    localparam int unsigned DefValN = 5;
    localparam int unsigned DefValP = 1;

    // Default widths and debounce length.
    localparam int unsigned DefCntW           = 8;
    localparam int unsigned DefTotW           = 16;
    localparam int unsigned DefDebounceCycles = 50000;

    // True when the debounced (accepted) level is "beam broken".
    function automatic logic is_broken(input db_state_e s);
        return (s == StStableBroken) || (s == StPendClear);
    endfunction

endpackage

// File: rtl/beam_debounce.sv
// One beam: 2-flop synchroniser, debounce FSM and break event generator.
module beam_debounce
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      beam_n,
    output db_state_e state,
    output logic      break_evt
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic            sync1_q, sync2_q;
    logic [1:0]      warm_q;
    logic            armed_q, armed_d;
    db_state_e       state_q, state_d;
    logic [CntW-1:0] dcnt_q, dcnt_d;
    logic            evt_q, evt_d;
    logic            smp_broken;

    assign smp_broken = ~sync2_q;

    // Armed only once a real (post-reset) unbroken sample has been seen, so a beam
    // still broken across reset is never counted. warm_q marks when sync2_q holds
    // real data rather than its preset value.
    assign armed_d = armed_q | (warm_q[1] & sync2_q);

    // Synchroniser (preset unbroken) and debounce state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
            state_q <= StStableClear;
            dcnt_q  <= '0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= beam_n;
            sync2_q <= sync1_q;
            warm_q  <= {warm_q[0], 1'b1};
            armed_q <= armed_d;
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            evt_q   <= evt_d;
        end
    end

    // Debounce next-state: a level change must persist past DEBOUNCE_CYCLES samples.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        evt_d   = 1'b0;
        case (state_q)
            StStableClear: begin
                if (smp_broken && armed_q) begin
                    state_d = StPendBreak;
                    dcnt_d  = CntOne;
                end
            end
            StPendBreak: begin
                if (!smp_broken) begin
                    state_d = StStableClear;
                    dcnt_d  = '0;
                end else if (dcnt_q == CntMax) begin
                    state_d = StStableBroken;
                    dcnt_d  = '0;
                    evt_d   = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CntOne;
                end
            end
            StStableBroken: begin
                if (!smp_broken) begin
                    state_d = StPendClear;
                    dcnt_d  = CntOne;
                end
            end
            StPendClear: begin
                if (smp_broken) begin
                    state_d = StStableBroken;
                    dcnt_d  = '0;
                end else if (dcnt_q == CntMax) begin
                    state_d = StStableClear;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + CntOne;
                end
            end
            default: begin
                state_d = StStableClear;
                dcnt_d  = '0;
            end
        endcase
    end

    // Outputs come straight from registered state.
    always_comb begin
        state     = state_q;
        break_evt = evt_q;
    end

endmodule

// File: rtl/coin_tally.sv
// Coin tally: four debounced beams feeding saturating per-coin counts and a cents total.
module coin_tally
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned VAL_Q           = DefValQ,
    parameter int unsigned VAL_D           = DefValD,
    parameter int unsigned VAL_N           = DefValN,
    parameter int unsigned VAL_P           = DefValP,
    parameter int unsigned CNT_W           = DefCntW,
    parameter int unsigned TOT_W           = DefTotW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       beam_n,
    input  logic             enable,
    input  logic             clear,
    output logic             coin_valid,
    output logic [3:0]       coin_mask,
    output logic [CNT_W-1:0] cnt_q,
    output logic [CNT_W-1:0] cnt_d,
    output logic [CNT_W-1:0] cnt_n,
    output logic [CNT_W-1:0] cnt_p,
    output logic [TOT_W-1:0] total_cents,
    output logic [3:0]       beam_state
);

    db_state_e          db_state [NumBeams];
    logic [3:0]         break_evt;
    logic [3:0]         evt;
    logic               valid_q, valid_d;
    logic [3:0]         mask_q, mask_d;
    logic [CNT_W-1:0]   count_q [NumBeams];
    logic [CNT_W-1:0]   count_d [NumBeams];
    logic [TOT_W-1:0]   total_q, total_d;
    logic [TOT_W:0]     add, sum;

    for (genvar i = 0; i < NumBeams; i++) begin : g_beam
        beam_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_beam_debounce (
            .clock    (clock),
            .reset    (reset),
            .beam_n   (beam_n[i]),
            .state    (db_state[i]),
            .break_evt(break_evt[i])
        );
    end

    // Events are dropped (not queued) while counting is disabled.
    assign evt = break_evt & {4{enable}};

    // Next tally values: saturating counts, total summed one bit wider and clamped.
    always_comb begin
        valid_d = |evt;
        mask_d  = evt;
        add     = '0;
        if (evt[CoinQ]) add = add + (TOT_W+1)'(VAL_Q);
        if (evt[CoinD]) add = add + (TOT_W+1)'(VAL_D);
        if (evt[CoinN]) add = add + (TOT_W+1)'(VAL_N);
        if (evt[CoinP]) add = add + (TOT_W+1)'(VAL_P);
        sum = {1'b0, total_q} + add;
        for (int i = 0; i < NumBeams; i++) begin
            count_d[i] = count_q[i];
            if (clear) begin
                count_d[i] = '0;
            end else if (evt[i] && (count_q[i] != {CNT_W{1'b1}})) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end
        end
        if (clear) begin
            total_d = '0;
        end else if (sum[TOT_W]) begin
            total_d = {TOT_W{1'b1}};
        end else begin
            total_d = sum[TOT_W-1:0];
        end
    end

    // Tally and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            mask_q  <= '0;
            total_q <= '0;
            for (int i = 0; i < NumBeams; i++) count_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            mask_q  <= mask_d;
            total_q <= total_d;
            for (int i = 0; i < NumBeams; i++) count_q[i] <= count_d[i];
        end
    end

    // Output mapping, including debounced broken flags for diagnostics.
    always_comb begin
        coin_valid  = valid_q;
        coin_mask   = mask_q;
        cnt_q       = count_q[CoinQ];
        cnt_d       = count_q[CoinD];
        cnt_n       = count_q[CoinN];
        cnt_p       = count_q[CoinP];
        total_cents = total_q;
        for (int i = 0; i < NumBeams; i++) beam_state[i] = is_broken(db_state[i]);
    end

endmodule
